regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 32, number of registers, with DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have parameter NRD, default 2, number of read ports, range 1..8.
REQ-005 The block SHALL have parameter NWR, default 2, number of write ports, range 1..4.
REQ-006 The block SHALL have port clk, input, 1 bit, the only clock; one clock; reset is synchronous and active-high.
REQ-007 The block SHALL have port rst, input, 1 bit, synchronous active-high reset sampled on the rising edge of clk.
REQ-008 The block SHALL have port we, input, NWR bits, per-write-port write enable.
REQ-009 The block SHALL have port wa, input, NWR*ADDR_W bits, flattened write addresses, with port k at bits [k*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port wd, input, NWR*DATA_W bits, flattened write data, with the same packing as wa.
REQ-011 The block SHALL have port ra, input, NRD*ADDR_W bits, flattened read addresses.
REQ-012 The block SHALL have port rd, output, NRD*DATA_W bits, flattened read data.
REQ-013 The block SHALL have port busy, output, 1 bit, high while the clear sequence runs.
REQ-014 The block SHALL have port wr_conflict, output, 1 bit, registered flag for a same-address write collision.

Function
REQ-015 The block SHALL use a two-state FSM, CLEAR and READY.
REQ-016 In CLEAR, a counter SHALL zero one register per cycle, index 0 up to DEPTH-1, then move to READY on the cycle after index DEPTH-1 is written.
REQ-017 In CLEAR, busy SHALL be 1, every we SHALL be ignored, and every rd port SHALL return 0.
REQ-018 In READY, busy SHALL be 0 and each write port with we[k]=1 SHALL update reg[wa_k] on the rising edge of clk.
REQ-019 Register 0 SHALL always read as 0, and writes to address 0 SHALL be discarded.
REQ-020 A write or read address >= DEPTH SHALL be ignored on write and SHALL read as 0.
REQ-021 When two or more enabled write ports target the same nonzero address, the highest-index port SHALL win.
REQ-022 On such a collision, wr_conflict SHALL be 1 in the following cycle only; otherwise wr_conflict SHALL be 0.
REQ-023 Read ports SHALL be combinational and mutually independent, with any ra allowed on any port.
REQ-024 Write-through bypass behaviour is defined in REQ-029 and REQ-030.

Reset
REQ-025 While rst=1, the FSM SHALL be held in CLEAR, the counter SHALL be held at 0, busy SHALL be 1, wr_conflict SHALL be 0, and rd SHALL be 0.
REQ-026 After rst deasserts, busy SHALL stay high for exactly DEPTH cycles.
REQ-027 Asserting rst mid-CLEAR SHALL restart the counter at 0; asserting rst in READY SHALL re-enter CLEAR.
REQ-028 Register contents SHALL be undefined only until the clear completes, and SHALL never be observable during that time because rd is forced to 0 (REQ-017).

Configuration
REQ-029 With macro REGFILE_MP_BYPASS_EN defined, a read of address A in the same cycle as an enabled READY write to A != 0 SHALL return the winning port's wd combinationally.
REQ-030 Without REGFILE_MP_BYPASS_EN, such a read SHALL return the stored old value, and the new value SHALL be visible from the next cycle.

Structure
REQ-031 Package regfile_mp_pkg SHALL hold the default DATA_W, ADDR_W, DEPTH, NRD and NWR constants and the FSM state typedef (CLEAR, READY).
REQ-032 The clear FSM and counter SHALL be a sub-module named regfile_mp_clrseq, with outputs busy, clr_en and clr_idx.
REQ-033 Write priority and the bypass mux SHALL remain in regfile_mp.

Verification
REQ-034 Reset and clear: hold rst for 3 cycles, then release -> busy=1 for exactly 32 cycles then 0; all 32 registers read 0; a write issued while busy leaves the target register at 0.
REQ-035 Basic and x0: write reg5=64'hDEAD_BEEF_F00D_0001 and reg0=64'hFFFF -> next cycle rd0(ra=5)=DEAD_BEEF_F00D_0001 and rd1(ra=0)=0.
REQ-036 Collision: port0 writes reg10=64'h1111, port1 writes reg10=64'h2222 in the same cycle -> reg10=64'h2222 and wr_conflict=1 for exactly one cycle.
REQ-037 Bypass: same-cycle write reg12=64'h1234_5678_9ABC_DEF0 and read ra=12 -> rd=the new value with REGFILE_MP_BYPASS_EN defined, the old value without it.
REQ-038 Mid-clear reset: assert rst at clear index 17 -> counter restarts at 0 and busy stays high for 32 cycles after release.
REQ-039 Random stress: 500 cycles of random we, wa, wd and ra on all ports, checked against a behavioural model with priority and bypass -> 0 mismatches.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg -- shared constants and types for the multi-port register file.
//   DEF_*    : default parameter values used by regfile_mp and regfile_mp_if
//   state_t  : clear-sequencer FSM state (CLEAR while zeroing, READY afterwards)
package regfile_mp_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NRD    = 2;
  localparam int DEF_NWR    = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if -- bundle of the register-file access signals.
//   we, wa, wd  : per-write-port enable, address, data (port k at [k*W +: W])
//   ra, rd      : per-read-port address and combinational read data
//   busy        : clear sequence running; writes ignored and rd forced to 0
//   wr_conflict : registered same-address write collision flag
//   state       : clear-sequencer FSM state, for observation
// Handshake: there is no valid/ready pair. A write is offered by raising we[k]
// for one cycle and is accepted on that rising edge whenever busy is 0; when
// busy is 1 the offer is dropped, not stalled. Reads need no qualifier.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR
);
  logic [NWR-1:0]        we;
  logic [NWR*ADDR_W-1:0] wa;
  logic [NWR*DATA_W-1:0] wd;
  logic [NRD*ADDR_W-1:0] ra;
  logic [NRD*DATA_W-1:0] rd;
  logic                  busy;
  logic                  wr_conflict;
  state_t                state;

  modport master (
    output we, wa, wd, ra,
    input  rd, busy, wr_conflict, state
  );

  modport slave (
    input  we, wa, wd, ra,
    output rd, busy, wr_conflict, state
  );
endinterface

// File: rtl/regfile_mp_clrseq.sv
// regfile_mp_clrseq -- clear sequencer. After reset it walks clr_idx from 0 to
// DEPTH-1, one register per cycle, then parks in READY.
//   clk, rst : clock, synchronous active-high reset (restarts the walk at 0)
//   busy     : registered, high while in CLEAR
//   clr_en   : zero register clr_idx on this edge
//   clr_idx  : register being zeroed
//   state    : FSM state for observation
module regfile_mp_clrseq
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx,
  output state_t            state
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state   <= READY;
            clr_idx <= '0;
            busy_q  <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        READY: begin
          busy_q <= 1'b0;
        end
        default: begin
          state  <= CLEAR;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign clr_en = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port register file with post-reset clear sequence.
//   clk : clock
//   rst : synchronous active-high reset; forces busy=1, rd=0, wr_conflict=0
//   bus : regfile_mp_if.slave (we/wa/wd write ports, ra/rd read ports,
//         busy, wr_conflict, state)
// Register 0 reads as 0 and ignores writes; addresses >= DEPTH are ignored on
// write and read as 0. On same-address writes the highest-index port wins.
// Optional feature, macro REGFILE_MP_BYPASS_EN: a read of an address being
// written this cycle returns the winning write data instead of the old value.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic              seq_busy;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;
  state_t            seq_state;

  regfile_mp_clrseq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clrseq (
    .clk     (clk),
    .rst     (rst),
    .busy    (seq_busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx),
    .state   (seq_state)
  );

  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] wa_a [NWR];
  logic [DATA_W-1:0] wd_a [NWR];
  logic [NWR-1:0]    wr_ok;
  logic [ADDR_W-1:0] ra_a [NRD];
  logic [NRD-1:0]    ra_ok;
  logic [DATA_W-1:0] rd_a [NRD];
  logic              busy_o;
  logic              conflict_now;
  logic              conflict_q;

  // Reset must show busy immediately, even while the registered state is READY.
  assign busy_o = rst | seq_busy;

  for (genvar k = 0; k < NWR; k++) begin : g_wr
    assign wa_a[k]  = bus.wa[k*ADDR_W +: ADDR_W];
    assign wd_a[k]  = bus.wd[k*DATA_W +: DATA_W];
    // A write lands only on a nonzero, in-range address.
    assign wr_ok[k] = bus.we[k] && (wa_a[k] != '0) && ({1'b0, wa_a[k]} < DEPTH_V);
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign ra_a[i]  = bus.ra[i*ADDR_W +: ADDR_W];
    assign ra_ok[i] = (ra_a[i] != '0) && ({1'b0, ra_a[i]} < DEPTH_V);
    assign bus.rd[i*DATA_W +: DATA_W] = rd_a[i];
  end

  // Ascending port order: the last non-blocking update (highest port) wins.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      regs[clr_idx[IDX_W-1:0]] <= '0;
    end else if (!rst) begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_ok[k]) regs[wa_a[k][IDX_W-1:0]] <= wd_a[k];
      end
    end
  end

  always_comb begin
    conflict_now = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      for (int k = j + 1; k < NWR; k++) begin
        if (wr_ok[j] && wr_ok[k] && (wa_a[j] == wa_a[k])) conflict_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) conflict_q <= 1'b0;
    else     conflict_q <= conflict_now & ~busy_o;
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_a[i] = '0;
      if (!busy_o && ra_ok[i]) begin
        rd_a[i] = regs[ra_a[i][IDX_W-1:0]];
`ifdef REGFILE_MP_BYPASS_EN
        for (int k = 0; k < NWR; k++) begin
          if (wr_ok[k] && (wa_a[k] == ra_a[i])) rd_a[i] = wd_a[k];
        end
`else
`endif
      end
    end
  end

  assign bus.busy        = busy_o;
  assign bus.wr_conflict = conflict_q & ~rst;
  assign bus.state       = seq_state;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- self-checking bench for regfile_mp (default parameters).
// A behavioural model of the register file is stepped on every rising edge and
// compared against busy, wr_conflict and every rd port on every falling edge;
// directed sequences add literal expectations for reset/clear, x0, collision,
// bypass and mid-clear reset, followed by a random stress phase.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int NRD    = 2;
  localparam int NWR    = 2;

  logic clk;
  logic rst;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .NRD    (NRD),
    .NWR    (NWR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [DATA_W-1:0] m_regs [DEPTH];
  int                m_clear_left = DEPTH;
  bit                m_conf = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wa_of(input int k);
    logic [ADDR_W-1:0] a;
    a = bus.wa[k*ADDR_W +: ADDR_W];
    return int'(a);
  endfunction

  function automatic int ra_of(input int i);
    logic [ADDR_W-1:0] a;
    a = bus.ra[i*ADDR_W +: ADDR_W];
    return int'(a);
  endfunction

  function automatic logic [DATA_W-1:0] wd_of(input int k);
    return bus.wd[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rd_of(input int i);
    return bus.rd[i*DATA_W +: DATA_W];
  endfunction

  // Model: a register array plus a count of clear cycles still to run.
  always @(posedge clk) begin
    if (rst) begin
      m_clear_left = DEPTH;
      m_conf       = 1'b0;
      chk_en       = 1'b1;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0) begin
        for (int r = 0; r < DEPTH; r++) m_regs[r] = '0;
      end
      m_conf = 1'b0;
    end else begin
      bit seen [DEPTH];
      m_conf = 1'b0;
      for (int r = 0; r < DEPTH; r++) seen[r] = 1'b0;
      for (int k = 0; k < NWR; k++) begin
        int a;
        a = wa_of(k);
        if (bus.we[k] && a != 0 && a < DEPTH) begin
          if (seen[a]) m_conf = 1'b1;
          seen[a]   = 1'b1;
          m_regs[a] = wd_of(k);
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] exp_rd(input int a);
    if (rst || m_clear_left > 0) return '0;
    if (a == 0 || a >= DEPTH) return '0;
`ifdef REGFILE_MP_BYPASS_EN
    for (int k = NWR - 1; k >= 0; k--) begin
      if (bus.we[k] && wa_of(k) == a) return wd_of(k);
    end
`endif
    return m_regs[a];
  endfunction

  // Compare process: every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", DATA_W'(bus.busy), DATA_W'(rst || m_clear_left > 0));
      check("wr_conflict", DATA_W'(bus.wr_conflict), DATA_W'(!rst && m_conf));
      for (int i = 0; i < NRD; i++) begin
        check($sformatf("rd%0d(ra=%0d)", i, ra_of(i)), rd_of(i), exp_rd(ra_of(i)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int k, input int a, input logic [DATA_W-1:0] d);
    bus.we[k] = 1'b1;
    bus.wa[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    bus.wd[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_ra(input int i, input int a);
    bus.ra[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic clr_we();
    bus.we = '0;
  endtask

  // Called just after rst is released: counts falling edges with busy high,
  // dropping any write enables after a few cycles so none reach READY.
  task automatic count_busy(output int n);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      tick();
      if (n == 5) clr_we();
    end
  endtask

  task automatic sweep_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      tick();
      set_ra(0, a);
      set_ra(1, DEPTH - 1 - a);
      @(negedge clk);
      check({tag, "_rd0"}, rd_of(0), '0);
      check({tag, "_rd1"}, rd_of(1), '0);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  localparam logic [DATA_W-1:0] V_DEAD = 64'hDEAD_BEEF_F00D_0001;
  localparam logic [DATA_W-1:0] V_BYP  = 64'h1234_5678_9ABC_DEF0;

  initial begin
    int n;
    rst    = 1'b1;
    bus.we = '0;
    bus.wa = '0;
    bus.wd = '0;
    bus.ra = '0;

    // Reset held for 3 cycles, then clear; a write offered while busy is lost.
    repeat (3) tick();
    set_wr(0, 7, 64'hABC);
    rst = 1'b0;
    count_busy(n);
    check("clear_busy_cycles", DATA_W'(n), 64'd32);
    clr_we();
    sweep_zero("after_clear");

    // Basic write plus discarded write to x0.
    tick();
    set_wr(0, 5, V_DEAD);
    set_wr(1, 0, 64'hFFFF);
    tick();
    clr_we();
    set_ra(0, 5);
    set_ra(1, 0);
    @(negedge clk);
    check("basic_reg5", rd_of(0), V_DEAD);
    check("x0_reads_zero", rd_of(1), '0);

    // Two ports, different addresses: both land, no conflict.
    tick();
    set_wr(0, 3, 64'h3333);
    set_wr(1, 4, 64'h4444);
    tick();
    clr_we();
    set_ra(0, 3);
    set_ra(1, 4);
    @(negedge clk);
    check("dual_reg3", rd_of(0), 64'h3333);
    check("dual_reg4", rd_of(1), 64'h4444);
    check("dual_no_conflict", DATA_W'(bus.wr_conflict), '0);

    // Same-address collision: port 1 wins, flag for one cycle.
    tick();
    set_wr(0, 10, 64'h1111);
    set_wr(1, 10, 64'h2222);
    tick();
    clr_we();
    set_ra(0, 10);
    @(negedge clk);
    check("collision_reg10", rd_of(0), 64'h2222);
    check("collision_flag", DATA_W'(bus.wr_conflict), 64'd1);
    tick();
    @(negedge clk);
    check("collision_flag_drop", DATA_W'(bus.wr_conflict), '0);

    // Same-cycle write and read of reg12.
    tick();
    set_wr(0, 12, 64'h55);
    tick();
    clr_we();
    set_wr(1, 12, V_BYP);
    set_ra(0, 12);
    @(negedge clk);
`ifdef REGFILE_MP_BYPASS_EN
    check("bypass_same_cycle", rd_of(0), V_BYP);
`else
    check("no_bypass_same_cycle", rd_of(0), 64'h55);
`endif
    tick();
    clr_we();
    @(negedge clk);
    check("bypass_next_cycle", rd_of(0), V_BYP);

    // Random stress; small address window half the time to provoke collisions.
    for (int c = 0; c < 500; c++) begin
      tick();
      for (int k = 0; k < NWR; k++) begin
        bus.we[k] = 1'($urandom_range(0, 1));
        bus.wa[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, (c % 2 == 0) ? 7 : DEPTH - 1));
        bus.wd[k*DATA_W +: DATA_W] = {$urandom, $urandom};
      end
      for (int i = 0; i < NRD; i++) set_ra(i, $urandom_range(0, (c % 2 == 0) ? 7 : DEPTH - 1));
    end
    tick();
    clr_we();

    // Reset in READY: busy and zero reads immediately.
    set_ra(0, 5);
    set_ra(1, 10);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready_busy", DATA_W'(bus.busy), 64'd1);
    check("rst_ready_rd0", rd_of(0), '0);
    tick();
    rst = 1'b0;

    // Reset when the clear walk is at index 17; the walk restarts from 0.
    repeat (17) tick();
    check("midclear_still_busy", DATA_W'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    count_busy(n);
    check("midclear_busy_cycles", DATA_W'(n), 64'd32);
    sweep_zero("after_midclear");

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
